sha256_padder: RTL and testbench
================================

SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 Parameter BITLEN_W, default 64: width of the internal message bit-length counter (range 32..64); it is zero-extended to 64 bits in the length field.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rstn  input  1  reset, asynchronous and active-low.
REQ-004 start_i  input  1  one-cycle pulse that begins a new message; it is ignored unless the state is IDLE or DONE.
REQ-005 in_valid_i  input  1  the input word is valid.
REQ-006 in_ready_o  output  1  the block accepts the input word.
REQ-007 in_dat_i  input  32  message word, big-endian: byte 0 is in [31:24].
REQ-008 in_last_i  input  1  this word is the final message word.
REQ-009 in_nbytes_i  input  3  valid bytes in the last word, 0..4; the value is ignored when in_last_i=0 (treated as 4).
REQ-010 fifo_full_i  input  1  the downstream SHA-256 input FIFO has at most 1 free entry (programmable full).
REQ-011 fifo_wr_en_o  output  1  write strobe into the downstream FIFO.
REQ-012 fifo_wr_dat_o  output  32  padded word to the downstream FIFO.
REQ-013 busy_o  output  1  a message is being padded.
REQ-014 done_o  output  1  the full padded message has been written; held until the next start.
REQ-015 blocks_o  output  16  number of 512-bit blocks emitted for the current message.

Function
REQ-016 States:
- IDLE
- DATA: accept input.
- PAD: emit the 0x80 word.
- ZERO: emit zero words.
- LENH: emit bit length [63:32].
- LENL: emit bit length [31:0].
- DONE
REQ-017 IDLE/DONE + start_i -> DATA: clear the bit counter, word index widx (4 bit), blocks_o and done_o; set busy_o.
REQ-018 in_ready_o = (state==DATA) & !fifo_full_i, combinational; a word is accepted when in_valid_i & in_ready_o.
REQ-019 Each accepted word, or each word generated in PAD/ZERO/LENH/LENL (only while !fifo_full_i), drives fifo_wr_en_o=1 with fifo_wr_dat_o in the next cycle, giving 1-cycle latency and at most 1 word/cycle.
REQ-020 Each emitted word increments widx modulo 16; on the wrap 15->0, blocks_o increments.
REQ-021 An accepted word with in_last_i=0 adds 32 to the bit counter and is forwarded unchanged.
REQ-022 Last word with nbytes n in 1..3: forward bytes 0..n-1 unchanged, set byte n to 0x80 and clear the lower bytes; add 8n to the counter; the 0x80 byte is then placed, so skip PAD.
REQ-023 Last word with n=4: forward unchanged, add 32, then enter PAD.
REQ-024 Last word with n=0: the word is consumed but not emitted; enter PAD directly.
REQ-025 PAD emits 0x80000000.
REQ-026 After the 0x80 byte is placed, the next state depends on the post-increment widx:
- widx==14: go to LENH.
- otherwise: go to ZERO; ZERO emits 0x00000000 until the post-increment widx==14, then goes to LENH (this crosses a block boundary when the 0x80 landed at index 14 or 15).
REQ-027 LENH emits counter[63:32]; LENL emits counter[31:0]; LENL's write wraps widx to 0, increments blocks_o, and sets the state to DONE, done_o=1, busy_o=0.
REQ-028 When fifo_full_i=1 the block emits nothing, freezes all state, and holds fifo_wr_en_o=0.
REQ-029 The bit counter wraps modulo 2^BITLEN_W with no error flag.
REQ-030 start_i while busy is ignored; in_valid_i outside DATA is ignored and not acknowledged.

Reset
REQ-031 rstn=0 asynchronously forces:
- state=IDLE; bit counter, widx and blocks_o to 0;
- fifo_wr_en_o=0, fifo_wr_dat_o=0;
- in_ready_o=0, busy_o=0, done_o=0.
REQ-032 Reset mid-message abandons the message; words already written to the FIFO are not retracted, and flushing the FIFO is the system's responsibility.

Structure
REQ-033 A shared package sha256_pkg holds the state enum, the SHA256_PAD_BYTE constant (8'h80), SHA256_BLOCK_WORDS=16 and SHA256_LEN_IDX=14; sha256_engine constants migrate there later.
REQ-034 A single sub-module, sha256_lastword_mask (combinational byte mask plus 0x80 insert), is natural; everything else stays flat.

Verification
REQ-035 "abc": one word 0x61626300, last, n=3 -> 16 words: 0x61626380, 13x 0x00000000, 0x00000000, 0x00000018; blocks_o=1; done_o=1.
REQ-036 Empty message: one word, last, n=0 -> 0x80000000, 13x zero, 0x00000000, 0x00000000; blocks_o=1.
REQ-037 56 bytes (14 full words, last n=4) -> 14 data words, 0x80000000, 0x00000000, 14x zero, 0x00000000, 0x000001C0; blocks_o=2.
REQ-038 "abc" with fifo_full_i toggling randomly -> the identical 16-word sequence, no writes while full, in_ready_o=0 while full.
REQ-039 rstn pulsed low after 5 words -> all outputs at reset values immediately; a new "abc" message then pads correctly.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions.
// Holds the padder state encoding and the padding constants. Other sha256_*
// blocks import this package, so constants used by more than one block
// belong here.
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PAD,
    ST_ZERO,
    ST_LENH,
    ST_LENL,
    ST_DONE
  } state_t;

  localparam logic [7:0]  SHA256_PAD_BYTE    = 8'h80;
  localparam logic [31:0] SHA256_PAD_WORD    = {SHA256_PAD_BYTE, 24'h000000};
  localparam int          SHA256_BLOCK_WORDS = 16;
  localparam logic [3:0]  SHA256_LEN_IDX     = 4'd14;

endpackage

// File: rtl/sha256_padder_if.sv
// Stream interface of the SHA-256 padder.
// Carries the message-word input handshake, the write port into the
// downstream SHA-256 FIFO, and the status outputs.
//   master : message source / system side (drives start, words, fifo_full)
//   slave  : the padder
interface sha256_padder_if;
  logic        start_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_dat_i;
  logic        in_last_i;
  logic [2:0]  in_nbytes_i;
  logic        fifo_full_i;
  logic        fifo_wr_en_o;
  logic [31:0] fifo_wr_dat_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] blocks_o;

  modport master (
    output start_i, in_valid_i, in_dat_i, in_last_i, in_nbytes_i, fifo_full_i,
    input  in_ready_o, fifo_wr_en_o, fifo_wr_dat_o, busy_o, done_o, blocks_o
  );

  modport slave (
    input  start_i, in_valid_i, in_dat_i, in_last_i, in_nbytes_i, fifo_full_i,
    output in_ready_o, fifo_wr_en_o, fifo_wr_dat_o, busy_o, done_o, blocks_o
  );
endinterface

// File: rtl/sha256_lastword_mask.sv
// Final-word byte mask for the SHA-256 padder.
// Keeps bytes 0..n-1 of a big-endian word (byte 0 in [31:24]), places the
// 0x80 pad byte at byte n and clears the bytes below it. For n = 0 or 4
// the word passes through unchanged; the padder handles those cases itself.
//   dat_i    : message word
//   nbytes_i : valid bytes in the word
//   dat_o    : masked word
module sha256_lastword_mask
  import sha256_pkg::*;
(
  input  logic [31:0] dat_i,
  input  logic [2:0]  nbytes_i,
  output logic [31:0] dat_o
);

  always_comb begin
    dat_o = dat_i;
    case (nbytes_i)
      3'd1:    dat_o = {dat_i[31:24], SHA256_PAD_BYTE, 16'h0000};
      3'd2:    dat_o = {dat_i[31:16], SHA256_PAD_BYTE, 8'h00};
      3'd3:    dat_o = {dat_i[31:8],  SHA256_PAD_BYTE};
      default: dat_o = dat_i;
    endcase
  end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder.
// Accepts a message as big-endian 32-bit words and writes the padded message
// (data, 0x80 byte, zero fill, 64-bit bit length) into the downstream
// SHA-256 input FIFO, one word per cycle at most, one cycle after the word
// is accepted or generated.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : sha256_padder_if.slave (input words, FIFO write port, status)
//   BITLEN_W  : bit-length counter width (32..64), zero-extended to 64 bits
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int BITLEN_W = 64
) (
  input  logic           clk,
  input  logic           rstn,
  sha256_padder_if.slave bus
);

  state_t              st;
  logic [BITLEN_W-1:0] bitcnt;
  logic [3:0]          widx;
  logic [15:0]         blocks;
  logic                busy;
  logic                done;
  logic                vld_p1;
  logic [31:0]         dat_p1;

  logic                in_ready;
  logic                accept;
  logic [2:0]          nb_eff;
  logic [BITLEN_W-1:0] add_bits;
  logic [31:0]         masked;
  logic [63:0]         len64;
  logic [3:0]          widx_nx;
  logic                wrap;
  logic                emit;
  logic [31:0]         emit_dat;

  // A non-final word always counts as four bytes; out-of-range counts clamp to 4.
  assign nb_eff   = (!bus.in_last_i || bus.in_nbytes_i > 3'd4) ? 3'd4 : bus.in_nbytes_i;
  assign add_bits = BITLEN_W'({nb_eff, 3'b000});
  assign in_ready = (st == ST_DATA) && !bus.fifo_full_i;
  assign accept   = bus.in_valid_i && in_ready;
  assign len64    = 64'(bitcnt);
  assign widx_nx  = widx + 4'd1;
  assign wrap     = (widx == 4'(SHA256_BLOCK_WORDS - 1));

  sha256_lastword_mask u_mask (
    .dat_i    (bus.in_dat_i),
    .nbytes_i (nb_eff),
    .dat_o    (masked)
  );

  // Word produced this cycle, if any. An empty final word is swallowed.
  always_comb begin
    emit     = 1'b0;
    emit_dat = '0;
    case (st)
      ST_DATA: begin
        emit     = accept && (nb_eff != 3'd0);
        emit_dat = masked;
      end
      ST_PAD: begin
        emit     = !bus.fifo_full_i;
        emit_dat = SHA256_PAD_WORD;
      end
      ST_ZERO: begin
        emit     = !bus.fifo_full_i;
        emit_dat = '0;
      end
      ST_LENH: begin
        emit     = !bus.fifo_full_i;
        emit_dat = len64[63:32];
      end
      ST_LENL: begin
        emit     = !bus.fifo_full_i;
        emit_dat = len64[31:0];
      end
      default: ;
    endcase
  end

  // Stage p0 -> p1: registered FIFO write and FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st     <= ST_IDLE;
      bitcnt <= '0;
      widx   <= '0;
      blocks <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      vld_p1 <= 1'b0;
      dat_p1 <= '0;
    end else begin
      vld_p1 <= emit;
      if (emit) begin
        dat_p1 <= emit_dat;
        widx   <= widx_nx;
        if (wrap) blocks <= blocks + 16'd1;
      end
      case (st)
        ST_IDLE, ST_DONE: begin
          if (bus.start_i) begin
            st     <= ST_DATA;
            bitcnt <= '0;
            widx   <= '0;
            blocks <= '0;
            done   <= 1'b0;
            busy   <= 1'b1;
          end
        end
        ST_DATA: begin
          if (accept) begin
            bitcnt <= bitcnt + add_bits;
            if (bus.in_last_i) begin
              // Full or empty last word still needs the 0x80 word; a partial
              // one already carries the pad byte.
              if (nb_eff == 3'd4 || nb_eff == 3'd0) st <= ST_PAD;
              else st <= (widx_nx == SHA256_LEN_IDX) ? ST_LENH : ST_ZERO;
            end
          end
        end
        ST_PAD, ST_ZERO: begin
          if (!bus.fifo_full_i) st <= (widx_nx == SHA256_LEN_IDX) ? ST_LENH : ST_ZERO;
        end
        ST_LENH: begin
          if (!bus.fifo_full_i) st <= ST_LENL;
        end
        ST_LENL: begin
          if (!bus.fifo_full_i) begin
            st   <= ST_DONE;
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready_o    = in_ready;
  assign bus.fifo_wr_en_o  = vld_p1;
  assign bus.fifo_wr_dat_o = dat_p1;
  assign bus.busy_o        = busy;
  assign bus.done_o        = done;
  assign bus.blocks_o      = blocks;

endmodule

// File: tb/tb_sha256_padder.sv
// Directed testbench for sha256_padder: known messages with hand-computed
// padded word streams, back-pressure from the FIFO, and mid-message reset.
module tb_sha256_padder;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  sha256_padder_if bus();

  sha256_padder #(.BITLEN_W(64)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic        rand_full    = 1'b0;
  logic        full_at_edge = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO back-pressure source, changed just after each rising edge.
  initial begin
    bus.fifo_full_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.fifo_full_i = rand_full ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  always @(posedge clk) full_at_edge <= bus.fifo_full_i;

  // FIFO-side monitor: collect writes, police back-pressure.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.fifo_wr_en_o) begin
        got_q.push_back(bus.fifo_wr_dat_o);
        check("wr_while_full", 64'(full_at_edge), 64'd0);
      end
      if (bus.fifo_full_i) check("ready_while_full", 64'(bus.in_ready_o), 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_msg();
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic last, input logic [2:0] n);
    int k;
    bus.in_valid_i  = 1'b1;
    bus.in_dat_i    = d;
    bus.in_last_i   = last;
    bus.in_nbytes_i = n;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.in_ready_o && k < 200);
    if (!bus.in_ready_o) check("ready_timeout", 64'd0, 64'd1);
    tick();
    bus.in_valid_i = 1'b0;
    bus.in_last_i  = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!bus.done_o && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", 64'(bus.done_o), 64'd1);
    @(negedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic push_zeros(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(32'h0);
  endtask

  task automatic compare(input string name, input int exp_blocks);
    check({name, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_w%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
    check({name, "_blocks"}, 64'(bus.blocks_o), 64'(exp_blocks));
    check({name, "_done"}, 64'(bus.done_o), 64'd1);
    check({name, "_busy"}, 64'(bus.busy_o), 64'd0);
  endtask

  task automatic run_abc(input string name);
    clr();
    start_msg();
    check({name, "_busy_start"}, 64'(bus.busy_o), 64'd1);
    send(32'h61626300, 1'b1, 3'd3);
    wait_done();
    exp_q.push_back(32'h61626380);
    push_zeros(14);
    exp_q.push_back(32'h00000018);
    compare(name, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start_i     = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.in_dat_i    = '0;
    bus.in_last_i   = 1'b0;
    bus.in_nbytes_i = '0;

    // Reset values
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en",  64'(bus.fifo_wr_en_o),  64'd0);
    check("rst_wr_dat", 64'(bus.fifo_wr_dat_o), 64'd0);
    check("rst_ready",  64'(bus.in_ready_o),    64'd0);
    check("rst_busy",   64'(bus.busy_o),        64'd0);
    check("rst_done",   64'(bus.done_o),        64'd0);
    check("rst_blocks", 64'(bus.blocks_o),      64'd0);
    rstn = 1'b1;
    tick();
    check("idle_ready", 64'(bus.in_ready_o), 64'd0);

    // "abc", 3-byte last word
    run_abc("abc");

    // Empty message
    clr();
    start_msg();
    send(32'hDEADBEEF, 1'b1, 3'd0);
    wait_done();
    exp_q.push_back(32'h80000000);
    push_zeros(15);
    compare("empty", 1);

    // 56 bytes: pad byte lands at index 14, spilling into a second block;
    // a start pulse mid-message must be ignored.
    clr();
    start_msg();
    for (int i = 0; i < 14; i++) begin
      send(32'h01020304 + 32'(i), (i == 13), 3'd4);
      exp_q.push_back(32'h01020304 + 32'(i));
      if (i == 2) start_msg();
    end
    wait_done();
    exp_q.push_back(32'h80000000);
    push_zeros(15);
    push_zeros(1);
    exp_q.push_back(32'h000001C0);
    compare("b56", 2);

    // 5 bytes: last word n=1, garbage in the dropped bytes
    clr();
    start_msg();
    send(32'h41424344, 1'b0, 3'd0);
    send(32'h45FFFFFF, 1'b1, 3'd1);
    wait_done();
    exp_q.push_back(32'h41424344);
    exp_q.push_back(32'h45800000);
    push_zeros(13);
    exp_q.push_back(32'h00000028);
    compare("b5", 1);

    // "ab": last word n=2
    clr();
    start_msg();
    send(32'h6162A5A5, 1'b1, 3'd2);
    wait_done();
    exp_q.push_back(32'h61628000);
    push_zeros(14);
    exp_q.push_back(32'h00000010);
    compare("ab", 1);

    // "abc" under random FIFO back-pressure
    rand_full = 1'b1;
    run_abc("abc_bp");
    rand_full = 1'b0;
    tick();

    // Reset after five words, then a fresh "abc"
    start_msg();
    for (int i = 0; i < 5; i++) send(32'h11111111 * 32'(i + 1), 1'b0, 3'd4);
    check("mid_busy", 64'(bus.busy_o), 64'd1);
    #2 rstn = 1'b0;
    #1;
    check("arst_wr_en",  64'(bus.fifo_wr_en_o),  64'd0);
    check("arst_wr_dat", 64'(bus.fifo_wr_dat_o), 64'd0);
    check("arst_ready",  64'(bus.in_ready_o),    64'd0);
    check("arst_busy",   64'(bus.busy_o),        64'd0);
    check("arst_done",   64'(bus.done_o),        64'd0);
    check("arst_blocks", 64'(bus.blocks_o),      64'd0);
    tick();
    rstn = 1'b1;
    tick();
    run_abc("abc_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
